// File: rtl/shift_deserializer_8bit_if.sv
// Bus bundle for the serial-in/parallel-out receiver: serial source side plus
// the word consumer side.
interface shift_deserializer_8bit_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             serial_in;
  logic             serial_valid;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic [CW-1:0]    bit_count;
  logic             overrun;

  modport master (
    output serial_in, serial_valid, flush, data_ready,
    input  data_out, data_valid, bit_count, overrun
  );

  modport slave (
    input  serial_in, serial_valid, flush, data_ready,
    output data_out, data_valid, bit_count, overrun
  );
endinterface

// File: rtl/shift_deserializer_8bit.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words from a qualified
// bit stream and holds each completed word in a one-deep output register.
module shift_deserializer_8bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  shift_deserializer_8bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Handshake: a word transfers on a rising edge where data_valid=1 and
  // data_ready=1; data_valid never drops without a transfer, and data_ready
  // while data_valid=0 is ignored.
  out_state_t       out_state, out_state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    bit_count_q;
  logic [WIDTH-1:0] data_q;
  logic             overrun_q;
  logic             accept_bit;
  logic             complete;
  logic             load_word;
  logic             drop_word;

  assign accept_bit = bus.serial_valid && !bus.flush;
  assign complete   = accept_bit && (bit_count_q == CW'(WIDTH - 1));
  assign word_next  = MSB_FIRST ? {shreg[WIDTH-2:0], bus.serial_in}
                                : {bus.serial_in, shreg[WIDTH-1:1]};

  always_comb begin
    out_state_next = out_state;
    load_word      = 1'b0;
    drop_word      = 1'b0;
    case (out_state)
      OUT_EMPTY: begin
        if (complete) begin
          out_state_next = OUT_FULL;
          load_word      = 1'b1;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          // A consume on the completing edge frees the slot for the new word.
          if (bus.data_ready) load_word = 1'b1;
          else                drop_word = 1'b1;
        end else if (bus.data_ready) begin
          out_state_next = OUT_EMPTY;
        end
      end
      default: out_state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= OUT_EMPTY;
    end else begin
      out_state <= out_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bit_count_q <= '0;
    end else if (bus.flush) begin
      shreg       <= '0;
      bit_count_q <= '0;
    end else if (accept_bit) begin
      shreg       <= complete ? '0 : word_next;
      bit_count_q <= complete ? '0 : bit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load_word) data_q <= word_next;
      if (bus.flush)      overrun_q <= 1'b0;
      else if (drop_word) overrun_q <= 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = (out_state == OUT_FULL);
  assign bus.bit_count  = bit_count_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_shift_deserializer_8bit.sv
// Bench for shift_deserializer_8bit: one MSB-first and one LSB-first instance
// share the same stimulus and are checked against a bit-queue reference model.
module tb_shift_deserializer_8bit;
  localparam int W = 8;

  logic clk;
  logic reset;

  shift_deserializer_8bit_if #(.WIDTH(W)) bus_m ();
  shift_deserializer_8bit_if #(.WIDTH(W)) bus_l ();

  shift_deserializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m.slave)
  );

  shift_deserializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l.slave)
  );

  assign bus_l.serial_in    = bus_m.serial_in;
  assign bus_l.serial_valid = bus_m.serial_valid;
  assign bus_l.flush        = bus_m.flush;
  assign bus_l.data_ready   = bus_m.data_ready;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word_msb;
  logic [W-1:0] m_word_lsb;
  logic         m_valid;
  logic         m_ovr;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".msb.data_out"},   32'(bus_m.data_out),   32'(m_word_msb));
    check({tag, ".lsb.data_out"},   32'(bus_l.data_out),   32'(m_word_lsb));
    check({tag, ".msb.data_valid"}, 32'(bus_m.data_valid), 32'(m_valid));
    check({tag, ".lsb.data_valid"}, 32'(bus_l.data_valid), 32'(m_valid));
    check({tag, ".msb.bit_count"},  32'(bus_m.bit_count),  32'(bit_q.size()));
    check({tag, ".lsb.bit_count"},  32'(bus_l.bit_count),  32'(bit_q.size()));
    check({tag, ".msb.overrun"},    32'(bus_m.overrun),    32'(m_ovr));
    check({tag, ".lsb.overrun"},    32'(bus_l.overrun),    32'(m_ovr));
  endtask

  task automatic model_reset();
    bit_q.delete();
    m_word_msb = '0;
    m_word_lsb = '0;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
  endtask

  // One rising edge with the given inputs, then the model update.
  task automatic model_edge(input logic b, input logic sv, input logic rdy, input logic fl);
    logic         complete;
    logic [W-1:0] w_msb;
    logic [W-1:0] w_lsb;
    complete = 1'b0;
    w_msb    = '0;
    w_lsb    = '0;
    if (fl) begin
      bit_q.delete();
      m_ovr = 1'b0;
    end else if (sv) begin
      bit_q.push_back(b);
      if (bit_q.size() == W) begin
        complete = 1'b1;
        for (int i = 0; i < W; i++) begin
          w_msb = w_msb * 2 + W'(bit_q[i]);
          if (bit_q[i]) w_lsb = w_lsb + (W'(1) << i);
        end
        bit_q.delete();
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_word_msb = w_msb;
        m_word_lsb = w_lsb;
        m_valid    = 1'b1;
        exp_q.push_back(w_msb);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input logic b, input logic sv, input logic rdy, input logic fl, input string tag);
    bus_m.serial_in    = b;
    bus_m.serial_valid = sv;
    bus_m.data_ready   = rdy;
    bus_m.flush        = fl;
    @(posedge clk);
    model_edge(b, sv, rdy, fl);
    @(negedge clk);
    bus_m.serial_valid = 1'b0;
    bus_m.data_ready   = 1'b0;
    bus_m.flush        = 1'b0;
    check_all(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input string tag);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) begin
      step(v[i], 1'b1, (i == 0) ? rdy_last : 1'b0, 1'b0, tag);
    end
  endtask

  task automatic idle(input logic rdy, input logic fl, input string tag);
    step(1'b0, 1'b0, rdy, fl, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_m.serial_in    = 1'b0;
    bus_m.serial_valid = 1'b0;
    bus_m.data_ready   = 1'b0;
    bus_m.flush        = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    idle(1'b0, 1'b0, "post_reset");

    // 1,0,1,0,... : AA msb-first, 55 lsb-first
    send_word(8'hAA, 1'b0, "basic");
    check("basic.aa", 32'(bus_m.data_out), 32'h0000_00AA);
    check("basic.55", 32'(bus_l.data_out), 32'h0000_0055);
    idle(1'b1, 1'b0, "basic.consume");

    // gapped C3: three idle cycles after the 4th bit
    for (int i = 7; i >= 4; i--) step(1'(8'hC3 >> i), 1'b1, 1'b0, 1'b0, "gap.hi");
    for (int g = 0; g < 3; g++) begin
      idle(1'b0, 1'b0, "gap.idle");
      check("gap.bit_count", 32'(bus_m.bit_count), 32'd4);
    end
    for (int i = 3; i >= 0; i--) step(1'(8'hC3 >> i), 1'b1, 1'b0, 1'b0, "gap.lo");
    check("gap.c3", 32'(bus_m.data_out), 32'h0000_00C3);
    idle(1'b1, 1'b0, "gap.consume");

    // back-pressure overrun, then flush, then consume
    send_word(8'hAA, 1'b0, "ovr.first");
    send_word(8'h0F, 1'b0, "ovr.second");
    check("ovr.kept", 32'(bus_m.data_out), 32'h0000_00AA);
    check("ovr.flag", 32'(bus_m.overrun), 32'd1);
    idle(1'b0, 1'b1, "ovr.flush");
    check("ovr.cleared", 32'(bus_m.overrun), 32'd0);
    check("ovr.still_valid", 32'(bus_m.data_valid), 32'd1);
    idle(1'b1, 1'b0, "ovr.consume");
    check("ovr.consumed", 32'(bus_m.data_valid), 32'd0);

    // consume and complete on the same edge
    send_word(8'hAA, 1'b0, "sim.first");
    send_word(8'h3C, 1'b1, "sim.second");
    check("sim.3c", 32'(bus_m.data_out), 32'h0000_003C);
    check("sim.valid", 32'(bus_m.data_valid), 32'd1);
    check("sim.no_ovr", 32'(bus_m.overrun), 32'd0);

    // flush on the completing edge discards the bit
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "flush.bits");
    step(1'b1, 1'b1, 1'b0, 1'b1, "flush.edge");
    check("flush.word_kept", 32'(bus_m.data_out), 32'h0000_003C);

    // reset mid-word between edges
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "rst.partial");
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("rst.async");
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0, 1'b0, "rst.release");
    send_word(8'h81, 1'b0, "rst.after");
    check("rst.81", 32'(bus_m.data_out), 32'h0000_0081);
    idle(1'b1, 1'b0, "rst.consume");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0),
           "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_deserializer_8bit.md
Name: shift_deserializer_8bit

Overview:
- Serial-in, parallel-out receiver: the opposite end of the 8-bit parallel-load shift register's serial stream.
- Accepts one bit per qualified clock and assembles WIDTH-bit words.
- Presents each completed word on a registered output with a valid/ready handshake.
- Flags overrun when the consumer stalls and a new word completes.

Parameters:
- WIDTH, 8, word length in bits (2..32).
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled on this edge when 1.
- flush  input  1  synchronous clear of the partial word and the overrun flag.
- data_out  output  WIDTH  last completed word; held until consumed.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out on an edge where data_valid=1 and data_ready=1.
- bit_count  output  log2(WIDTH)+1  bits of the current partial word (0..WIDTH-1).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (reset=0, asynchronous): shift register=0, bit_count=0, data_out=0, data_valid=0, overrun=0. All outputs hold these values while reset=0 and from deassertion until the first qualifying edge.
- A reset asserted mid-word discards the partial word and any pending output word.
- Internal states:
  - COLLECT: bit_count 0..WIDTH-1.
  - Output register: EMPTY (data_valid=0) or FULL (data_valid=1).
- Shift, MSB_FIRST=1: on an edge with serial_valid=1, shreg <= {shreg[WIDTH-2:0], serial_in}.
- Shift, MSB_FIRST=0: on an edge with serial_valid=1, shreg <= {serial_in, shreg[WIDTH-1:1]}.
- bit_count increments on each accepted bit.
- With serial_valid=0, shreg and bit_count hold. Gaps of any length are legal.
- Word completion occurs when bit_count==WIDTH-1 and serial_valid=1 on an edge.
  - On that same edge: the completed word (including the current bit) goes to the output stage and bit_count wraps to 0.
  - Latency: data_valid=1 and data_out=word are visible immediately after the edge that samples the WIDTH-th bit (0 extra cycles).
- Consume: an edge with data_valid=1 and data_ready=1 clears data_valid, unless a completion occurs on the same edge. data_out value is don't-care-stable: it holds the old word.
- Completion vs. output-register state:
  - Completion with output EMPTY: load data_out, set data_valid.
  - Completion with output FULL and data_ready=1 on the same edge: load the new word, data_valid stays 1, no overrun.
  - Completion with output FULL and data_ready=0: keep the old data_out, drop the new word, set overrun=1. bit_count still wraps to 0.
- overrun stays 1 until flush or reset.
- data_ready while data_valid=0 has no effect.
- flush=1 on an edge: bit_count=0, shreg=0, overrun=0. data_out and data_valid are unaffected, except that a consume on the same edge is still honoured.
  - flush has priority over serial_valid: a bit sampled on a flush edge is discarded and no completion occurs.
- bit_count never exceeds WIDTH-1; it wraps on completion only.

Test Plan:
- Basic word, MSB_FIRST=1: release reset, then drive serial_valid=1 with bits 1,0,1,0,1,0,1,0 on 8 consecutive edges, data_ready=0 → data_valid rises after the 8th edge, data_out=8'hAA, bit_count=0, overrun=0.
- Bit order, MSB_FIRST=0: same bit sequence → data_out=8'h55.
- Gapped input: insert serial_valid=0 for 3 cycles between bits 4 and 5 of 8'hC3 → data_out=8'hC3 after the 8th valid bit, and bit_count holds 4 during the gap.
- Back-pressure overrun: hold data_ready=0, send 8'hAA then 8'h0F → data_out stays 8'hAA, overrun=1. Then pulse flush → overrun=0, data_valid still 1. Then pulse data_ready → data_valid=0.
- Simultaneous consume and complete: data_valid=1 with 8'hAA; assert data_ready=1 on the edge carrying the 8th bit of 8'h3C → data_out=8'h3C, data_valid=1, overrun=0.
- Reset mid-word: after 5 bits of 8'hFF, drive reset=0 between clock edges → bit_count=0 and data_valid=0 immediately. After release, a full 8'h81 → data_out=8'h81, with no residue from the aborted word.
